// File: rtl/io_read_ctrl.sv
// ---------------------------------------------------------------------------
// IoReadCtrl (module io_read_ctrl)
//
// Input-side I/O controller feeding the CPU load path through MemOrIo.
// The switch bank and the confirm button are brought into the clock domain
// with 2-flop synchronisers. The button is debounced by a four-state FSM.
// Every accepted press snapshots the switches and raises a ready flag.
// CPU I/O reads return either the snapshot or a status word.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst_n          synchronous active-low reset
//   sw_i           raw asynchronous switch levels (SW_WIDTH bits)
//   btn_i          raw asynchronous confirm button, bouncy, active-high
//   ior_i          CPU I/O read strobe, one cycle per load
//   sel_i          register select: 0 = data snapshot, 1 = status
//   ioread_data_o  registered read data back to MemOrIo
//   ready_o        snapshot-valid flag (also drives an LED)
//
// Status word layout: {30'b0, overrun, ready}
// ---------------------------------------------------------------------------
module io_read_ctrl #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] sw_i,
    input  logic                btn_i,
    input  logic                ior_i,
    input  logic                sel_i,
    output logic [31:0]         ioread_data_o,
    output logic                ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] r_swMeta;
    logic [SW_WIDTH-1:0] r_swSync;
    logic                r_btnMeta;
    logic                r_btnSync;

    state_t              r_state;
    state_t              w_stateNext;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cntNext;
    logic                w_capture;

    logic [31:0]         r_snapshot;
    logic                r_ready;
    logic                r_overrun;
    logic [31:0]         r_readData;

    logic                w_dataRead;
    logic                w_statusRead;
    logic [31:0]         w_swExt;

    // Two-stage synchronisers; nothing else looks at the raw pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_swMeta  <= '0;
            r_swSync  <= '0;
            r_btnMeta <= 1'b0;
            r_btnSync <= 1'b0;
        end else begin
            r_swMeta  <= sw_i;
            r_swSync  <= r_swMeta;
            r_btnMeta <= btn_i;
            r_btnSync <= r_btnMeta;
        end
    end

    // Debounce FSM state and stability counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state logic. The counter only advances while it is below
    // CNT_LAST, so it can never wrap. A press is accepted exactly once,
    // on the PRESS_WAIT -> PRESSED transition. A short bounce during
    // release falls back to PRESSED without a second capture.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_btnSync) begin
                    w_stateNext = ST_PRESS_WAIT;
                    w_cntNext   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_btnSync) begin
                    w_stateNext = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = ST_PRESSED;
                    w_capture   = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!r_btnSync) begin
                    w_stateNext = ST_RELEASE_WAIT;
                    w_cntNext   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_btnSync) begin
                    w_stateNext = ST_PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    assign w_dataRead   = ior_i & ~sel_i;
    assign w_statusRead = ior_i &  sel_i;
    assign w_swExt      = 32'(r_swSync);

    // Snapshot, flags and read-data register.
    // When a capture and a read land on the same edge, the read returns
    // the pre-edge contents. The capture still takes effect: ready stays
    // set, and the new snapshot replaces the old one.
    // Overrun is set only when the capture finds ready already set and no
    // data read is consuming it on the same edge. A status read clears
    // overrun unless this very capture overran.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snapshot <= '0;
            r_ready    <= 1'b0;
            r_overrun  <= 1'b0;
            r_readData <= '0;
        end else begin
            if (w_dataRead) begin
                r_readData <= r_snapshot;
            end else if (w_statusRead) begin
                r_readData <= {30'b0, r_overrun, r_ready};
            end

            if (w_capture) begin
                r_snapshot <= w_swExt;
            end

            if (w_capture) begin
                r_ready <= 1'b1;
            end else if (w_dataRead) begin
                r_ready <= 1'b0;
            end

            if (w_capture && r_ready && !w_dataRead) begin
                r_overrun <= 1'b1;
            end else if (w_statusRead) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign ioread_data_o = r_readData;
    assign ready_o       = r_ready;

endmodule

// File: tb/tb_io_read_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for io_read_ctrl with DEBOUNCE_CYCLES = 4.
// The reference model tracks the debounced button as a level plus a
// run length of consecutive synchronised samples that disagree with it.
// The level flips once that run reaches DEBOUNCE_CYCLES+1 samples, and a
// 0 -> 1 flip is a capture. Flags and read data follow the read/capture
// rules directly. Directed scenarios also check literal values.
// ---------------------------------------------------------------------------
module tb_io_read_ctrl;

    localparam int D = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_i;
    logic        btn_i;
    logic        ior_i;
    logic        sel_i;
    logic [31:0] ioread_data_o;
    logic        ready_o;

    int testsRun;
    int testsFailed;

    // Reference model state
    bit          mLevel;
    int          mRun;
    bit          mBtnHist [2];
    logic [15:0] mSwHist  [2];
    logic [31:0] mSnap;
    bit          mReady;
    bit          mOverrun;
    logic [31:0] mData;

    io_read_ctrl #(
        .SW_WIDTH        (16),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_i          (sw_i),
        .btn_i         (btn_i),
        .ior_i         (ior_i),
        .sel_i         (sel_i),
        .ioread_data_o (ioread_data_o),
        .ready_o       (ready_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance the reference model by one rising edge using the inputs that
    // the DUT will sample on that edge.
    task automatic modelStep(input logic rst, input logic btn, input logic [15:0] sw,
                             input logic ior, input logic sel);
        bit          btnS;
        logic [15:0] swS;
        bit          capture;
        bit          dataRd;
        bit          statRd;
        if (!rst) begin
            mLevel      = 1'b0;
            mRun        = 0;
            mBtnHist[0] = 1'b0;
            mBtnHist[1] = 1'b0;
            mSwHist[0]  = '0;
            mSwHist[1]  = '0;
            mSnap       = '0;
            mReady      = 1'b0;
            mOverrun    = 1'b0;
            mData       = '0;
        end else begin
            btnS    = mBtnHist[1];
            swS     = mSwHist[1];
            capture = 1'b0;
            if (btnS != mLevel) begin
                mRun++;
                if (mRun == D + 1) begin
                    mLevel  = btnS;
                    mRun    = 0;
                    capture = btnS;
                end
            end else begin
                mRun = 0;
            end

            dataRd = ior && !sel;
            statRd = ior && sel;

            if (dataRd)      mData = mSnap;
            else if (statRd) mData = {30'b0, mOverrun, mReady};

            if (capture && mReady && !dataRd) mOverrun = 1'b1;
            else if (statRd)                  mOverrun = 1'b0;

            if (capture)     mReady = 1'b1;
            else if (dataRd) mReady = 1'b0;

            if (capture) mSnap = {16'b0, swS};

            mBtnHist[1] = mBtnHist[0];
            mBtnHist[0] = btn;
            mSwHist[1]  = mSwHist[0];
            mSwHist[0]  = sw;
        end
    endtask

    // Drive one cycle, step the model, wait for the edge and compare.
    task automatic applyStimulus(input logic rst, input logic btn, input logic [15:0] sw,
                                 input logic ior, input logic sel);
        rst_n = rst;
        btn_i = btn;
        sw_i  = sw;
        ior_i = ior;
        sel_i = sel;
        modelStep(rst, btn, sw, ior, sel);
        @(posedge clk);
        #1;
        checkOutput("model_ready", 32'(ready_o), 32'(mReady));
        checkOutput("model_data", ioread_data_o, mData);
    endtask

    task automatic holdBtn(input int n, input logic btn, input logic [15:0] sw);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, btn, sw, 1'b0, 1'b0);
    endtask

    task automatic readReg(input logic sel, input logic btn, input logic [15:0] sw);
        applyStimulus(1'b1, btn, sw, 1'b1, sel);
    endtask

    // Full press from a released state: 7 edges until the capture.
    task automatic pressCapture(input logic [15:0] sw, input string tag);
        holdBtn(D + 3, 1'b1, sw);
        checkOutput(tag, 32'(ready_o), 32'h1);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        btn_i = 1'b0;
        sw_i  = '0;
        ior_i = 1'b0;
        sel_i = 1'b0;
        @(negedge clk);

        // Reset held with button pressed and all switches high.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("rst_data", ioread_data_o, 32'h0);
        checkOutput("rst_ready", 32'(ready_o), 32'h0);
        holdBtn(D + 2, 1'b1, 16'hFFFF);
        checkOutput("rst_no_early_capture", 32'(ready_o), 32'h0);
        holdBtn(1, 1'b1, 16'hFFFF);
        checkOutput("rst_capture", 32'(ready_o), 32'h1);
        readReg(1'b0, 1'b1, 16'hFFFF);
        checkOutput("rst_snap", ioread_data_o, 32'h0000FFFF);
        holdBtn(10, 1'b0, 16'hFFFF);

        // Clean press.
        holdBtn(D + 2, 1'b1, 16'hA5C3);
        checkOutput("press_early", 32'(ready_o), 32'h0);
        holdBtn(1, 1'b1, 16'hA5C3);
        checkOutput("press_ready", 32'(ready_o), 32'h1);
        readReg(1'b0, 1'b1, 16'hA5C3);
        checkOutput("press_data", ioread_data_o, 32'h0000A5C3);
        checkOutput("press_cleared", 32'(ready_o), 32'h0);
        holdBtn(20, 1'b1, 16'hA5C3);
        checkOutput("held_once", 32'(ready_o), 32'h0);
        holdBtn(10, 1'b0, 16'hA5C3);

        // Bounce 1,0,1,0 then steady high.
        for (int k = 1; k <= 10; k++) begin
            holdBtn(1, (k <= 4) ? logic'(k % 2) : 1'b1, 16'h3C3C);
            if (k >= 4) checkOutput("bounce_no_capture", 32'(ready_o), 32'h0);
        end
        holdBtn(1, 1'b1, 16'h3C3C);
        checkOutput("bounce_capture", 32'(ready_o), 32'h1);
        readReg(1'b0, 1'b1, 16'h3C3C);
        checkOutput("bounce_data", ioread_data_o, 32'h00003C3C);
        holdBtn(10, 1'b0, 16'h3C3C);

        // Overrun: two captures without a read.
        pressCapture(16'h0001, "ovr_first");
        holdBtn(10, 1'b0, 16'h0001);
        pressCapture(16'h0002, "ovr_second");
        holdBtn(10, 1'b0, 16'h0002);
        readReg(1'b1, 1'b0, 16'h0002);
        checkOutput("ovr_status1", ioread_data_o, 32'h3);
        readReg(1'b1, 1'b0, 16'h0002);
        checkOutput("ovr_status2", ioread_data_o, 32'h1);
        readReg(1'b0, 1'b0, 16'h0002);
        checkOutput("ovr_data", ioread_data_o, 32'h2);

        // Capture and data read on the same edge.
        pressCapture(16'h1111, "sim_first");
        holdBtn(10, 1'b0, 16'h1111);
        holdBtn(D + 2, 1'b1, 16'h2222);
        readReg(1'b0, 1'b1, 16'h2222);
        checkOutput("sim_old_snap", ioread_data_o, 32'h00001111);
        checkOutput("sim_ready_kept", 32'(ready_o), 32'h1);
        readReg(1'b1, 1'b1, 16'h2222);
        checkOutput("sim_no_overrun", ioread_data_o, 32'h1);
        readReg(1'b0, 1'b1, 16'h2222);
        checkOutput("sim_new_snap", ioread_data_o, 32'h00002222);
        holdBtn(10, 1'b0, 16'h2222);

        // Capture and status read on the same edge, with ready already set.
        pressCapture(16'h4444, "simst_first");
        holdBtn(10, 1'b0, 16'h4444);
        holdBtn(D + 2, 1'b1, 16'h5555);
        readReg(1'b1, 1'b1, 16'h5555);
        checkOutput("simst_pre_edge", ioread_data_o, 32'h1);
        readReg(1'b1, 1'b1, 16'h5555);
        checkOutput("simst_overrun", ioread_data_o, 32'h3);
        readReg(1'b0, 1'b1, 16'h5555);
        checkOutput("simst_data", ioread_data_o, 32'h00005555);
        holdBtn(10, 1'b0, 16'h5555);

        // Release debounce: a short dip does not re-arm the press.
        pressCapture(16'h0A0A, "rel_first");
        readReg(1'b0, 1'b1, 16'h0A0A);
        checkOutput("rel_data1", ioread_data_o, 32'h00000A0A);
        holdBtn(2, 1'b0, 16'h0B0B);
        holdBtn(20, 1'b1, 16'h0B0B);
        checkOutput("rel_short_dip", 32'(ready_o), 32'h0);
        holdBtn(10, 1'b0, 16'h0B0B);
        pressCapture(16'h0B0B, "rel_repress");
        readReg(1'b0, 1'b1, 16'h0B0B);
        checkOutput("rel_data2", ioread_data_o, 32'h00000B0B);
        holdBtn(10, 1'b0, 16'h0B0B);

        // Reset in the middle of a press abandons it.
        holdBtn(4, 1'b1, 16'h7777);
        applyStimulus(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0);
        holdBtn(D + 2, 1'b1, 16'h7777);
        checkOutput("midrst_none", 32'(ready_o), 32'h0);
        holdBtn(1, 1'b1, 16'h7777);
        checkOutput("midrst_capture", 32'(ready_o), 32'h1);
        holdBtn(10, 1'b0, 16'h7777);

        // Randomised traffic against the model.
        begin
            logic        rBtn;
            logic [15:0] rSw;
            rBtn = 1'b0;
            rSw  = 16'h0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) rBtn = ~rBtn;
                if ($urandom_range(0, 3) == 0) rSw = 16'($urandom);
                applyStimulus(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                              rBtn, rSw,
                              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                              logic'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
